pwm_dac: RTL and testbench
==========================

// Module: pwm_dac
// PURPOSE
//  Downstream consumer of the function-generator wave sources (square/triangle/etc.).
//  Takes the 8-bit sample stream and applies digital amplitude scaling.
//  Converts the scaled sample to a single-bit PWM output for an RC-filtered board DAC.
//  Latches one sample per PWM frame and pulses sample_req so a source can advance in lock-step.
// PARAMETERS
//  WIDTH     8  sample/duty width; one frame = 2**WIDTH ticks
//  PRESCALE  1  clocks per PWM tick; legal range >= 1
// PORTS
//  clk         in   1      system clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  en          in   1      run enable; low forces IDLE
//  wave        in   WIDTH  unsigned input sample from wave source
//  amp         in   WIDTH  amplitude; gain = (amp+1)/2**WIDTH
//  pwm_out     out  1      registered PWM output
//  sample_req  out  1      one-clock pulse at every frame boundary/load
//  busy        out  1      high in LOAD or RUN
// BEHAVIOUR
//  Reset (async, immediate)
//   - pwm_out=0, sample_req=0, busy=0.
//   - Internal state: state=IDLE, cnt=0, pre=0, duty=0.
//  Scaling (combinational)
//   - scaled = (wave * (amp+1)) >> WIDTH.
//   - Uses a 2*WIDTH+1-bit product; no rounding or saturation.
//   - Full scale maps to full scale (255,255 -> 255); wave=0 -> 0.
//  FSM
//   - IDLE: pwm_out<=0, cnt<=0, pre<=0, sample_req<=0, busy<=0. en=1 -> LOAD.
//   - LOAD (exactly 1 clk):
//     - duty<=scaled; cnt<=0; pre<=0; sample_req<=1; busy<=1; pwm_out<=0.
//     - Next state RUN if en=1, else IDLE.
//   - RUN:
//     - busy=1.
//     - tick = (pre==PRESCALE-1); on tick pre<=0, else pre<=pre+1.
//     - pwm_out <= (cnt < duty), evaluated every clock with current cnt/duty.
//     - On tick with cnt<2**WIDTH-1: cnt<=cnt+1.
//     - On tick with cnt==2**WIDTH-1 (frame end): cnt<=0, duty<=scaled sampled that clock,
//       sample_req<=1 for that one clock. Otherwise sample_req<=0.
//     - en=0 -> IDLE next clock; the partial frame is abandoned.
//  Timing
//   - en sampled high at edge N: LOAD at N+1, first valid pwm_out at N+2.
//   - Frame length = PRESCALE * 2**WIDTH clocks.
//   - High time per frame = duty * PRESCALE clocks.
//   - duty=0 -> constant 0; duty=2**WIDTH-1 -> low for exactly 1 tick per frame.
//  Boundary rules
//   - wave/amp changes mid-frame have no effect until the next frame boundary or LOAD.
//   - cnt wraps only at frame end; no overflow path.
//   - en deassert on the same clock as frame end: go to IDLE; sample_req still pulses.
//   - Re-enable always passes through LOAD with fresh duty.
//   - rst mid-frame clears everything asynchronously; operation resumes via IDLE->LOAD.
// TESTING
//  - Reset: rst=1 at any time -> pwm_out=0, sample_req=0, busy=0 immediately; hold 0 with en=0.
//  - PRESCALE=1, wave=128, amp=255, en=1:
//    - pwm_out high 128 / low 128 clocks per 256-clock frame.
//    - sample_req pulses once every 256 clocks.
//  - Extremes: wave=255, amp=255 -> high 255 of 256 clocks; wave=0 -> pwm_out never high.
//  - Scaling: wave=200, amp=127 -> duty=100 (100 high clocks/frame).
//    - wave=255, amp=0 -> duty=0.
//  - Mid-frame change: wave 64->192 at clock 10 of a frame.
//    - Current frame stays 64 high; next frame 192 high.
//  - PRESCALE=4, wave=128, amp=255:
//    - 1024-clock frame, 512 high.
//    - en dropped mid-frame -> pwm_out=0 next clock; re-enable -> LOAD pulse then fresh frame.

Source files
------------

// File: rtl/pwm_dac.sv
// Amplitude-scaled PWM DAC: latches one scaled sample per frame and emits a single-bit
// PWM stream for an RC-filtered board DAC, pulsing sample_req at every load/frame boundary.
module pwm_dac #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] wave,
  input  logic [WIDTH-1:0] amp,
  output logic             pwm_out,
  output logic             sample_req,
  output logic             busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] duty, duty_nx;
  logic [PW-1:0]    pre, pre_nx;
  logic             pwm_nx, req_nx, busy_nx;
  logic [WIDTH-1:0] scaled;
  logic             tick, frame_end;

  // amp+1 makes amp=all-ones a unity gain, so full scale stays full scale.
  function automatic logic [WIDTH-1:0] scale(input logic [WIDTH-1:0] w,
                                             input logic [WIDTH-1:0] a);
    logic [2*WIDTH:0] w_ext, a_ext, prod;
    w_ext = (2*WIDTH+1)'(w);
    a_ext = (2*WIDTH+1)'(a) + 1'b1;
    prod  = w_ext * a_ext;
    return prod[2*WIDTH-1:WIDTH];
  endfunction

  assign scaled    = scale(wave, amp);
  assign tick      = (pre == PRE_LAST);
  assign frame_end = tick && (cnt == '1);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pre_nx   = pre;
    duty_nx  = duty;
    pwm_nx   = pwm_out;
    req_nx   = 1'b0;
    busy_nx  = busy;
    case (state)
      IDLE: begin
        pwm_nx  = 1'b0;
        cnt_nx  = '0;
        pre_nx  = '0;
        busy_nx = 1'b0;
        if (en) state_nx = LOAD;
      end
      LOAD: begin
        duty_nx  = scaled;
        cnt_nx   = '0;
        pre_nx   = '0;
        req_nx   = 1'b1;
        busy_nx  = 1'b1;
        pwm_nx   = 1'b0;
        state_nx = en ? RUN : IDLE;
      end
      RUN: begin
        busy_nx = 1'b1;
        pwm_nx  = (cnt < duty);
        // A frame-end pulse still fires if en drops on that same clock.
        if (tick) begin
          pre_nx = '0;
          if (frame_end) begin
            cnt_nx  = '0;
            duty_nx = scaled;
            req_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end else begin
          pre_nx = pre + 1'b1;
        end
        state_nx = en ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pre        <= '0;
      duty       <= '0;
      pwm_out    <= 1'b0;
      sample_req <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      pre        <= pre_nx;
      duty       <= duty_nx;
      pwm_out    <= pwm_nx;
      sample_req <= req_nx;
      busy       <= busy_nx;
    end
  end

endmodule

// File: tb/tb_pwm_dac.sv
// Bench for pwm_dac: two instances (PRESCALE 1 and 4) share stimulus and are compared every
// cycle against a frame-position model, plus directed duty/timing checks with literal values.
module tb_pwm_dac;
  localparam int W = 8;
  localparam int PS[2] = '{1, 4};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] wave = '0;
  logic [7:0] amp  = '0;
  logic       pwm[2], req[2], busy[2];

  always #5 clk = ~clk;

  pwm_dac #(.WIDTH(W), .PRESCALE(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .wave(wave), .amp(amp),
    .pwm_out(pwm[0]), .sample_req(req[0]), .busy(busy[0]));

  pwm_dac #(.WIDTH(W), .PRESCALE(4)) u1 (
    .clk(clk), .rst(rst), .en(en), .wave(wave), .amp(amp),
    .pwm_out(pwm[1]), .sample_req(req[1]), .busy(busy[1]));

  int ntests = 0;
  int nfail  = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int scale(input int w, input int a);
    return (w * (a + 1)) / 256;
  endfunction

  // Model: mode 0 idle, 1 load, 2 run; k is the clock position inside the current frame.
  int m_mode[2] = '{0, 0};
  int m_k[2]    = '{0, 0};
  int m_duty[2] = '{0, 0};
  bit e_pwm[2]  = '{0, 0};
  bit e_req[2]  = '{0, 0};
  bit e_busy[2] = '{0, 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] <= 0; m_k[i] <= 0; m_duty[i] <= 0;
        e_pwm[i] <= 0; e_req[i] <= 0; e_busy[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (m_mode[i])
          0: begin
            e_pwm[i] <= 0; e_req[i] <= 0; e_busy[i] <= 0;
            if (en) m_mode[i] <= 1;
          end
          1: begin
            m_duty[i] <= scale(int'(wave), int'(amp));
            m_k[i]    <= 0;
            e_req[i]  <= 1; e_busy[i] <= 1; e_pwm[i] <= 0;
            m_mode[i] <= en ? 2 : 0;
          end
          default: begin
            e_busy[i] <= 1;
            e_pwm[i]  <= (m_k[i] / PS[i]) < m_duty[i];
            if (m_k[i] == PS[i] * 256 - 1) begin
              m_k[i]    <= 0;
              m_duty[i] <= scale(int'(wave), int'(amp));
              e_req[i]  <= 1;
            end else begin
              m_k[i]   <= m_k[i] + 1;
              e_req[i] <= 0;
            end
            m_mode[i] <= en ? 2 : 0;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d.pwm_out", i), pwm[i], e_pwm[i]);
        check($sformatf("u%0d.sample_req", i), req[i], e_req[i]);
        check($sformatf("u%0d.busy", i), busy[i], e_busy[i]);
      end
    end
  end

  task automatic wait_req(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req[i] && n < 3000);
    check($sformatf("wait_req_u%0d", i), req[i], 1);
  endtask

  // Counts one frame starting just after a load/boundary pulse; optionally changes inputs mid-frame.
  task automatic measure(input int i, input int chg_at, input int cw, input int ca,
                         input int exp_hi, input string nm);
    int hi = 0;
    int rq = 0;
    for (int c = 0; c < PS[i] * 256; c++) begin
      @(negedge clk);
      hi += int'(pwm[i]);
      rq += int'(req[i]);
      if (c == chg_at) begin
        wave = 8'(cw);
        amp  = 8'(ca);
      end
    end
    check({nm, "_high"}, hi, exp_hi);
    check({nm, "_reqs"}, rq, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_pwm", pwm[i], 0);
      check("rst_req", req[i], 0);
      check("rst_busy", busy[i], 0);
    end
    rst = 1'b0;
    chk_on = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", busy[0], 0);

    check("scale_200_127", scale(200, 127), 100);
    check("scale_255_255", scale(255, 255), 255);
    check("scale_255_0", scale(255, 0), 0);

    wave = 8'd128; amp = 8'd255; en = 1'b1;
    @(negedge clk);
    check("load_lat_busy", busy[0], 0);
    @(negedge clk);
    check("load_req", req[0], 1);
    check("load_busy", busy[0], 1);
    check("load_pwm", pwm[0], 0);

    measure(0, 10, 255, 255, 128, "p1_w128");
    measure(0, 10, 0,   255, 255, "p1_w255");
    measure(0, 10, 200, 127, 0,   "p1_w0");
    measure(0, 10, 255, 0,   100, "p1_w200a127");
    measure(0, 10, 64,  255, 0,   "p1_w255a0");
    measure(0, 10, 192, 255, 64,  "p1_mid64");
    measure(0, 10, 128, 255, 192, "p1_mid192");

    wait_req(1);
    measure(1, -1, 0, 0, 512, "p4_w128");

    repeat (100) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("drop_busy1", busy[1], 1);
    @(negedge clk);
    check("drop_pwm", pwm[1], 0);
    check("drop_busy2", busy[1], 0);
    repeat (5) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("reen_busy0", busy[1], 0);
    @(negedge clk);
    check("reen_req", req[1], 1);
    check("reen_busy", busy[1], 1);
    measure(1, -1, 0, 0, 512, "p4_reen");

    wait_req(0);
    repeat (255) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("fe_drop_req", req[0], 1);
    @(negedge clk);
    check("fe_drop_busy", busy[0], 0);

    en = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      wave = 8'($urandom);
      amp  = 8'($urandom);
      if ($urandom_range(0, 400) == 0) en = ~en;
      if (c == 2500) begin
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
          check("async_rst_pwm", pwm[i], 0);
          check("async_rst_req", req[i], 0);
          check("async_rst_busy", busy[i], 0);
        end
        @(negedge clk);
        rst = 1'b0;
      end
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
